// File: rtl/pulse_sched.sv
//==============================================================================
// Module   : pulse_sched
// Purpose  : Collects rising-edge requests from NREQ lanes and serialises them
//            onto one shared pulse output. Lanes are served round-robin; each
//            pulse is PULSE_W cycles high and is followed by GAP idle cycles.
//            A request arriving on a lane that is already pending is dropped
//            and reported on the overflow strobe.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-high reset
//            sig       - [NREQ] per-lane request levels (rising edge = request)
//            pulse_sig - shared scheduled pulse
//            pulse_id  - [$clog2(NREQ)] lane owning the current pulse
//            pend      - [NREQ] per-lane pending flags
//            overflow  - one-cycle strobe when a request is dropped
// Options  : PULSE_SCHED_COUNT_EN - each lane keeps a 4-bit saturating count of
//            outstanding requests instead of a single pending bit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pulse_sched #(
    parameter int NREQ    = 4,
    parameter int PULSE_W = 1,
    parameter int GAP     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         sig,
    output logic                    pulse_sig,
    output logic [$clog2(NREQ)-1:0] pulse_id,
    output logic [NREQ-1:0]         pend,
    output logic                    overflow
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Terminal counts for the shared phase counter. GAP=0 never enters S_GAP,
    // so its terminal value is irrelevant there.
    localparam logic [3:0] PW_LAST  = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic [NREQ-1:0] prev;
    logic [IW-1:0]   last_grant;

    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] drop;
    logic [NREQ-1:0] grant_mask;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;

    assign rise = sig & ~prev;

    // Round-robin search starting just after the last granted lane.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_mask  = '0;
        if (state == S_IDLE) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!grant_valid && pend[(int'(last_grant) + k) % NREQ]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IW'((int'(last_grant) + k) % NREQ);
                end
            end
        end
        if (grant_valid) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

`ifdef PULSE_SCHED_COUNT_EN
    logic [3:0] count [NREQ];

    // Only an un-granted edge at a full counter is lost; an edge coinciding
    // with a grant cancels it and leaves the count unchanged.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = (count[i] != 4'd0);
            drop[i] = rise[i] && !grant_mask[i] && (count[i] == 4'hF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                count[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({rise[i] && !drop[i], grant_mask[i]})
                    2'b10:   count[i] <= count[i] + 4'd1;
                    2'b01:   count[i] <= count[i] - 4'd1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end
`else
    // The set term is OR-ed after the clear so an edge on the lane being
    // granted keeps it pending instead of being reported as a drop.
    assign drop = rise & pend & ~grant_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant_mask) | rise;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            prev       <= '0;
            pulse_sig  <= 1'b0;
            pulse_id   <= '0;
            overflow   <= 1'b0;
            last_grant <= IW'(NREQ - 1);
        end else begin
            prev     <= sig;
            overflow <= |drop;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        state      <= S_PULSE;
                        cnt        <= 4'd0;
                        pulse_sig  <= 1'b1;
                        pulse_id   <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                S_PULSE: begin
                    if (cnt == PW_LAST) begin
                        pulse_sig <= 1'b0;
                        cnt       <= 4'd0;
                        state     <= (GAP > 0) ? S_GAP : S_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= 4'd0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= 4'd0;
                    pulse_sig <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
